mod_counter: RTL
================

# mod_counter

Parametrised modulo-N up/down counter with synchronous clear, parallel load, terminal-count output for cascading, and an optional registered compare window. It is the general counting primitive for the VGA timing chain: one instance per axis, with the horizontal instance's `tc` driving the vertical instance's `en`. The compare window generates sync and active-video flags aligned with the count.

## Interface
- `WIDTH`, 10: counter width in bits.
- `MOD`, 800: count modulus; the count runs 0..MOD-1. Legal range is 2 <= MOD <= 2**WIDTH.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  load value.
- `down`  in  1  direction: 0 counts up, 1 counts down.
- `win_start`  in  WIDTH  first count of the compare window, inclusive.
- `win_end`  in  WIDTH  last count of the compare window, inclusive.
- `Q`  out  WIDTH  current count.
- `tc`  out  1  terminal count; combinational.
- `win`  out  1  registered flag: Q is inside the window.

## Operation
- Asynchronous reset (`reset`=0) forces Q=0 and win=0 immediately. tc is 0 while reset is asserted.
- At each rising edge, the first matching rule applies, in this priority order:
  1. `clr`=1: Q <= 0.
  2. `load`=1: Q <= load_val if load_val <= MOD-1; otherwise Q <= MOD-1 (saturate, never out of range).
  3. `en`=1, `down`=0: if Q==MOD-1, Q <= 0; otherwise Q <= Q+1.
  4. `en`=1, `down`=1: if Q==0, Q <= MOD-1; otherwise Q <= Q-1.
  5. Otherwise Q holds.
- tc = en & !clr & !load & ((!down & Q==MOD-1) | (down & Q==0)). tc is high for exactly the cycle whose edge performs the wrap.
- Arithmetic is WIDTH bits and unsigned. Q never leaves 0..MOD-1. When MOD = 2**WIDTH, wrap is the natural overflow.
- Window test on a value V:
  - If win_start <= win_end: V in [win_start, win_end].
  - If win_start > win_end (wrapping window): V >= win_start or V <= win_end.
- win is registered from the next-state value of Q. This makes win valid in the same cycle as the Q it describes, with no lag.
- `down`, `win_start` and `win_end` may change at any cycle. They take effect at the next edge.

## Timing
- Q has a latency of 1 edge from clr, load or en.
- tc is combinational from en, clr, load, down and Q. It has no register stage, so a downstream counter's `en` sees it in the same cycle.
- Window:
  - win updates on the same edge as Q.
  - After reset release, win is 0 until the first edge.
  - From that edge on, win equals the window test applied to Q.
- Reset mid-count: Q and win go to 0 asynchronously, with no dependency on clk. Counting resumes from 0 on the first edge after release.
- Simultaneous clr and load and en: clr wins, Q <= 0, tc=0.

## Configuration
- `MOD_COUNTER_WINDOW_EN` defined:
  - The window comparator and the win register are built.
  - win behaves as described above.
- `MOD_COUNTER_WINDOW_EN` undefined:
  - win is tied to constant 0.
  - win_start and win_end are present but unused.
  - No comparator logic is generated.
  - All other behaviour is identical.

## Test plan
- WIDTH=10, MOD=800, en=1, down=0, from reset:
  - Q steps 0,1,...,799,0.
  - tc is high only in the cycle Q=799, once every 800 cycles.
- Down count: load_val=3 with load=1, then en=1, down=1.
  - Q steps 3,2,1,0,799.
  - tc is high only while Q=0.
- Priority: at Q=10, assert clr=1, load=1, load_val=500, en=1 in one cycle.
  - Next Q=0 and tc=0.
  - Repeat with clr=0: next Q=500.
  - Then load_val=900: next Q=799 (saturated).
- Window (macro defined): win_start=656, win_end=751.
  - win=1 exactly while Q is 656..751.
  - Then win_start=790, win_end=5: win=1 for Q in 790..799 and 0..5.
- Reset mid-operation: drop reset at Q=400 between clock edges.
  - Q=0 and win=0 without waiting for a clock edge.
  - After release, Q=1 at the first edge with en=1.
- Macro undefined: repeat the window test. win stays 0 throughout while Q and tc match the macro-defined run.

Source files
------------

// File: rtl/mod_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mod_counter
// Brief    : Modulo-MOD up/down counter with clear, saturating load,
//            combinational terminal count and an optional registered compare
//            window (built only when MOD_COUNTER_WINDOW_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int WIDTH = 10,
  parameter int MOD   = 800
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             down,
  input  logic [WIDTH-1:0] win_start,
  input  logic [WIDTH-1:0] win_end,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             win
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_at_wrap;

  assign w_at_wrap = down ? (r_q == '0) : (r_q == c_MAX);

  always_comb begin
    w_q_next = r_q;
    if (clr) begin
      w_q_next = '0;
    end else if (load) begin
      w_q_next = (load_val <= c_MAX) ? load_val : c_MAX;
    end else if (en) begin
      if (down) begin
        w_q_next = (r_q == '0) ? c_MAX : r_q - WIDTH'(1);
      end else begin
        w_q_next = (r_q == c_MAX) ? '0 : r_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  // Gated by reset so a held-down counter sitting at 0 cannot fire a cascade.
  assign tc = reset & en & ~clr & ~load & w_at_wrap;
  assign Q  = r_q;

`ifdef MOD_COUNTER_WINDOW_EN
  logic r_win;
  logic w_win_next;

  // Evaluated on the next-state count so win lines up with the Q it describes.
  always_comb begin
    w_win_next = 1'b0;
    if (win_start <= win_end) begin
      w_win_next = (w_q_next >= win_start) && (w_q_next <= win_end);
    end else begin
      w_win_next = (w_q_next >= win_start) || (w_q_next <= win_end);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win <= 1'b0;
    end else begin
      r_win <= w_win_next;
    end
  end

  assign win = r_win;
`else
  logic w_unused_win;

  assign w_unused_win = ^{win_start, win_end};
  assign win          = 1'b0;
`endif

endmodule
`default_nettype wire
